// File: rtl/memory_pkg.sv
// Shared definitions for the data memory and the load/store unit:
// word geometry, the byte type and the store-width byte masks.
package memory_pkg;

    localparam int DATA_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef logic [7:0] byte_t;

    // Store-width masks, lane 0 anchored at the access address
    localparam logic [BYTES_PER_WORD-1:0] MASK_B = 4'b0001;
    localparam logic [BYTES_PER_WORD-1:0] MASK_H = 4'b0011;
    localparam logic [BYTES_PER_WORD-1:0] MASK_W = 4'b1111;

    // Extract byte lane k of a data word (lane k = bits [8k+7:8k])
    function automatic byte_t get_lane(input logic [DATA_W-1:0] word, input int k);
        return word[8*k +: 8];
    endfunction

endpackage

// File: rtl/memory.sv
// Byte-addressed data memory for the single-cycle RV32I core.
// Word accesses at any byte address, little-endian lane mapping, addresses
// wrap modulo DEPTH. Writes are synchronous with per-byte enables, reads are
// combinational, and reset clears every byte asynchronously.
module memory
    import memory_pkg::*;
#(
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [AW-1:0]             i_addr,
    input  logic [DATA_W-1:0]         i_wdata,
    input  logic [BYTES_PER_WORD-1:0] i_bmask,
    input  logic                      i_wren,
    output logic [DATA_W-1:0]         o_rdata
);

    byte_t         mem       [DEPTH];
    logic [AW-1:0] lane_addr [BYTES_PER_WORD];

    // Lane k touches byte (addr + k); DEPTH is a power of two, so the AW-bit
    // add wraps naturally from the top of memory back to byte 0.
    for (genvar k = 0; k < BYTES_PER_WORD; k++) begin : g_lane
        assign lane_addr[k]      = i_addr + AW'(k);
        assign o_rdata[8*k +: 8] = mem[lane_addr[k]];
    end

    // Byte array: async clear on reset, masked byte writes on the clock edge
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (i_wren) begin
            for (int k = 0; k < BYTES_PER_WORD; k++) begin
                if (i_bmask[k]) begin
                    mem[lane_addr[k]] <= get_lane(i_wdata, k);
                end
            end
        end
    end

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for the data memory: a byte-array model tracks every
// write, a compare process checks o_rdata against it each negedge, and
// directed scenarios pin literal values worked out by hand.
module tb_memory;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          i_clk;
    logic          i_reset;
    logic [AW-1:0] i_addr;
    logic [31:0]   i_wdata;
    logic [3:0]    i_bmask;
    logic          i_wren;
    logic [31:0]   o_rdata;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    logic [7:0] model_mem [DEPTH];

    memory #(.DEPTH(DEPTH)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_addr  (i_addr),
        .i_wdata (i_wdata),
        .i_bmask (i_bmask),
        .i_wren  (i_wren),
        .o_rdata (o_rdata)
    );

    initial i_clk = 0;
    always #5 i_clk = ~i_clk;

    // Reference model: a plain byte array with modulo addressing
    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        end else if (i_wren) begin
            for (int k = 0; k < 4; k++)
                if (i_bmask[k]) model_mem[(int'(i_addr) + k) % DEPTH] = i_wdata[8*k +: 8];
        end
    end

    function automatic logic [31:0] model_read(input int a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = model_mem[(a + k) % DEPTH];
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] expected);
        checks++;
        if (o_rdata !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (addr %0d, t=%0t)",
                     name, o_rdata, expected, i_addr, $time);
        end
    endtask

    // Every negedge, the combinational read must match the model at i_addr
    always @(negedge i_clk) begin
        if (cmp_en) checkOutput("model_read", model_read(int'(i_addr)));
    end

    // One write cycle: inputs set after the negedge, held across the posedge
    task automatic applyStimulus(input int addr, input logic [31:0] data,
                                 input logic [3:0] mask, input logic wren);
        @(negedge i_clk);
        #1;
        i_addr  = AW'(addr);
        i_wdata = data;
        i_bmask = mask;
        i_wren  = wren;
        @(posedge i_clk);
        #1;
        i_wren  = 0;
    endtask

    task automatic readCheck(input string name, input int addr, input logic [31:0] expected);
        i_addr = AW'(addr);
        #1;
        checkOutput(name, expected);
    endtask

    initial begin
        i_reset = 1;
        i_addr  = '0;
        i_wdata = '0;
        i_bmask = '0;
        i_wren  = 0;
        repeat (2) @(posedge i_clk);
        #2;
        i_reset = 0;
        cmp_en  = 1;

        // Reset: dirty a word, then pulse reset between edges
        applyStimulus(0, 32'h12345678, 4'b1111, 1);
        readCheck("pre_reset_word", 0, 32'h12345678);
        #1;
        i_reset = 1;
        #1;
        checkOutput("reset_immediate", 32'h0000_0000);
        for (int a = 0; a < 32; a += 4) readCheck("reset_held", a, 32'h0000_0000);
        i_reset = 0;

        // Full-word writes
        for (int i = 0; i < 32; i += 4) applyStimulus(i, 32'(i * 100), 4'b1111, 1);
        readCheck("full_a0",  0,  32'h0000_0000);
        readCheck("full_a4",  4,  32'h0000_0190);
        readCheck("full_a8",  8,  32'h0000_0320);
        readCheck("full_a12", 12, 32'h0000_04B0);
        readCheck("full_a28", 28, 32'h0000_0AF0);

        // Partial and unaligned writes
        applyStimulus(1, 32'hAAAABBBB, 4'b0001, 1);
        applyStimulus(2, 32'hCCCCDDDD, 4'b0010, 1);
        applyStimulus(3, 32'h11112222, 4'b0100, 1);
        applyStimulus(4, 32'h33334444, 4'b1000, 1);
        applyStimulus(5, 32'h55556666, 4'b0011, 1);
        applyStimulus(6, 32'h77778888, 4'b1100, 1);
        applyStimulus(7, 32'h9999AAAA, 4'b0111, 1);
        applyStimulus(8, 32'hBBBBCCCC, 4'b1110, 1);
        readCheck("part_a0",  0,  32'hDD00BB00);
        readCheck("part_a4",  4,  32'hAA666690);
        readCheck("part_a8",  8,  32'hBBBBCCAA);
        readCheck("part_a12", 12, 32'h0000_04B0);

        // Zero mask with write enable is a no-op
        applyStimulus(12, 32'hFFFFFFFF, 4'b0000, 1);
        readCheck("zero_mask", 12, 32'h0000_04B0);

        // Write-enable gating
        applyStimulus(16, 32'hDEADBEEF, 4'b1111, 0);
        readCheck("wren_gate", 16, 32'h0000_0640);

        // Wrap-around at the top of memory
        applyStimulus(30, 32'h44332211, 4'b1111, 1);
        readCheck("wrap_a30", 30, 32'h44332211);
        readCheck("wrap_a0",  0,  32'hDD004433);
        readCheck("wrap_a28", 28, 32'h22110AF0);

        // Read-during-write: old data before the edge, new data after it
        @(negedge i_clk);
        #1;
        i_addr  = AW'(4);
        i_wdata = 32'hCAFEF00D;
        i_bmask = 4'b1111;
        i_wren  = 1;
        #1;
        checkOutput("rdw_before_edge", 32'hAA666690);
        @(posedge i_clk);
        #1;
        checkOutput("rdw_after_edge", 32'hCAFEF00D);
        i_wren = 0;
        #2;
        i_reset = 1;
        #1;
        checkOutput("rdw_async_reset", 32'h0000_0000);
        readCheck("reset_a30", 30, 32'h0000_0000);
        #1;
        i_reset = 0;

        // Writes land again after reset is released
        applyStimulus(8, 32'h0BADF00D, 4'b0011, 1);
        readCheck("post_reset_half", 8, 32'h0000_F00D);

        repeat (2) @(posedge i_clk);
        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
